// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for pipe_skid_reg.
// The upstream side offers entries; the downstream side takes the main entry.
interface pipe_skid_reg_if #(
    parameter int DATA_W = 32,
    parameter int NCH    = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           IMcode_in;
    logic [31:0]           PC_in;
    logic [DATA_W*NCH-1:0] data_in;

    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           IMcode_out;
    logic [31:0]           PC_out;
    logic [DATA_W*NCH-1:0] data_out;

    logic [1:0]            count;

    modport master (
        output in_valid, IMcode_in, PC_in, data_in, out_ready,
        input  in_ready, out_valid, IMcode_out, PC_out, data_out, count
    );

    modport slave (
        input  in_valid, IMcode_in, PC_in, data_in, out_ready,
        output in_ready, out_valid, IMcode_out, PC_out, data_out, count
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer, flush and bubbles.
// in_ready depends only on registered state, never on out_ready.
module pipe_skid_reg #(
    parameter int          DATA_W   = 32,
    parameter int          NCH      = 2,
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] NOP_CODE = 32'h0000_0000
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Flush,
    pipe_skid_reg_if.slave  bus
);
    localparam int DW = DATA_W * NCH;

    typedef struct packed {
        logic [31:0]   imcode;
        logic [31:0]   pc;
        logic [DW-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam entry_t RST_E = {NOP_CODE, PC_RESET, {DW{1'b0}}};

    state_t state;
    state_t state_n;
    entry_t main_q;
    entry_t main_n;
    entry_t skid_q;
    entry_t skid_n;
    entry_t in_e;
    logic   in_fire;
    logic   out_fire;

    // A bubble keeps its PC so downstream still sees a sane address.
    function automatic entry_t bubble(entry_t e);
        entry_t b;
        b        = e;
        b.imcode = NOP_CODE;
        b.data   = '0;
        return b;
    endfunction

    assign in_e     = {bus.IMcode_in, bus.PC_in, bus.data_in};
    assign in_fire  = bus.in_valid & (state != FULL);
    assign out_fire = bus.out_ready & (state != EMPTY);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state  <= EMPTY;
            main_q <= RST_E;
            skid_q <= RST_E;
        end else begin
            state  <= state_n;
            main_q <= main_n;
            skid_q <= skid_n;
        end
    end

    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (Flush) begin
            state_n = EMPTY;
            main_n  = bubble(main_q);
            skid_n  = bubble(skid_q);
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_n  = in_e;
                        state_n = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_n = in_e;
                    end else if (in_fire) begin
                        skid_n  = in_e;
                        state_n = FULL;
                    end else if (out_fire) begin
                        main_n  = bubble(main_q);
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_n  = skid_q;
                        skid_n  = bubble(skid_q);
                        state_n = ONE;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    main_n  = bubble(main_q);
                    skid_n  = bubble(skid_q);
                end
            endcase
        end
    end

    always_comb begin
        unique case (state)
            ONE:     bus.count = 2'd1;
            FULL:    bus.count = 2'd2;
            default: bus.count = 2'd0;
        endcase
    end

    assign bus.in_ready   = (state != FULL);
    assign bus.out_valid  = (state != EMPTY);
    assign bus.IMcode_out = main_q.imcode;
    assign bus.PC_out     = main_q.pc;
    assign bus.data_out   = main_q.data;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: FIFO-level reference model plus directed
// scenarios with literal expectations, then a randomized soak.
module tb_pipe_skid_reg;
    localparam int DATA_W = 32;
    localparam int NCH    = 2;
    localparam int DW     = DATA_W * NCH;
    localparam logic [31:0] PC_RST = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    typedef struct {
        logic [31:0]   im;
        logic [31:0]   pc;
        logic [DW-1:0] data;
    } ent_t;

    logic CLK;
    logic rst;
    logic fl;

    int tests = 0;
    int fails = 0;

    pipe_skid_reg_if #(.DATA_W(DATA_W), .NCH(NCH)) bus ();

    pipe_skid_reg #(
        .DATA_W  (DATA_W),
        .NCH     (NCH),
        .PC_RESET(PC_RST),
        .NOP_CODE(NOP)
    ) dut (
        .CLK  (CLK),
        .Reset(rst),
        .Flush(fl),
        .bus  (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference model: an ordered queue of at most two entries, plus the
    // PC the output shows while nothing is held.
    ent_t        q[$];
    logic [31:0] hold_pc;
    bit          started = 0;

    always @(posedge CLK) begin
        bit of;
        bit inf;
        if (rst) begin
            q.delete();
            hold_pc = PC_RST;
            started = 1;
        end else if (fl) begin
            if (q.size() > 0) hold_pc = q[0].pc;
            q.delete();
        end else begin
            of  = bus.out_ready && (q.size() > 0);
            inf = bus.in_valid && (q.size() < 2);
            if (of) begin
                hold_pc = q[0].pc;
                void'(q.pop_front());
            end
            if (inf) q.push_back('{bus.IMcode_in, bus.PC_in, bus.data_in});
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
            chk("count", 64'(bus.count), 64'(q.size()));
            chk("IMcode_out", 64'(bus.IMcode_out),
                64'(q.size() > 0 ? q[0].im : NOP));
            chk("PC_out", 64'(bus.PC_out),
                64'(q.size() > 0 ? q[0].pc : hold_pc));
            chk("data_out", bus.data_out,
                q.size() > 0 ? q[0].data : 64'd0);
        end
    end

    task automatic step(input bit iv, input logic [31:0] pc,
                        input logic [31:0] im, input logic [DW-1:0] d,
                        input bit ordy, input bit f, input bit r);
        bus.in_valid  = iv;
        bus.PC_in     = pc;
        bus.IMcode_in = im;
        bus.data_in   = d;
        bus.out_ready = ordy;
        fl            = f;
        rst           = r;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input bit ordy);
        step(0, 32'hdead_beef, 32'hffff_ffff, '1, ordy, 0, 0);
    endtask

    initial begin
        rst           = 1'b1;
        fl            = 1'b0;
        bus.in_valid  = 1'b1;
        bus.PC_in     = 32'h0000_4444;
        bus.IMcode_in = 32'h1234_5678;
        bus.data_in   = 64'h1111_2222_3333_4444;
        bus.out_ready = 1'b1;

        // Reset two cycles with in_valid held high
        step(1, 32'h4444, 32'h1234_5678, 64'h55, 1, 0, 1);
        step(1, 32'h4444, 32'h1234_5678, 64'h55, 1, 0, 1);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_pc", 64'(bus.PC_out), 64'h3000);
        chk("rst_im", 64'(bus.IMcode_out), 64'd0);
        chk("rst_data", bus.data_out, 64'd0);

        // Streaming at full rate
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h3000 + 32'(4 * i), 32'h0100_0000 + 32'(i),
                 64'(i) << 8, 1, 0, 0);
            chk("stream_pc", 64'(bus.PC_out), 64'(32'h3000 + 32'(4 * i)));
            chk("stream_count", 64'(bus.count), 64'd1);
            chk("stream_ready", 64'(bus.in_ready), 64'd1);
        end
        idle(1);
        chk("stream_drained", 64'(bus.out_valid), 64'd0);

        // Backpressure: A then B into a stalled stage
        step(1, 32'h3020, 32'hAAAA_0001, 64'hA, 0, 0, 0);
        step(1, 32'h3024, 32'hBBBB_0002, 64'hB, 0, 0, 0);
        chk("bp_count", 64'(bus.count), 64'd2);
        chk("bp_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_hold_a", 64'(bus.PC_out), 64'h3020);
        idle(1);
        chk("bp_b_pc", 64'(bus.PC_out), 64'h3024);
        chk("bp_b_im", 64'(bus.IMcode_out), 64'hBBBB_0002);
        chk("bp_recover", 64'(bus.in_ready), 64'd1);
        idle(1);
        chk("bp_empty", 64'(bus.out_valid), 64'd0);

        // Drain to bubble keeps PC
        step(1, 32'h3030, 32'h8C01_0004, 64'h77, 0, 0, 0);
        idle(1);
        chk("bub_valid", 64'(bus.out_valid), 64'd0);
        chk("bub_im", 64'(bus.IMcode_out), 64'(NOP));
        chk("bub_data", bus.data_out, 64'd0);
        chk("bub_pc", 64'(bus.PC_out), 64'h3030);

        // Flush while full with a simultaneous offer
        step(1, 32'h3040, 32'hC000_0001, 64'h1, 0, 0, 0);
        step(1, 32'h3044, 32'hC000_0002, 64'h2, 0, 0, 0);
        step(1, 32'h3010, 32'hC000_0003, 64'h3, 0, 1, 0);
        chk("fl_count", 64'(bus.count), 64'd0);
        chk("fl_valid", 64'(bus.out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("fl_no_3010", 64'(bus.PC_out == 32'h3010), 64'd0);
        end

        // Reset mid-FULL, then resume streaming
        step(1, 32'h3050, 32'hD000_0001, 64'h5, 0, 0, 0);
        step(1, 32'h3054, 32'hD000_0002, 64'h6, 0, 0, 0);
        step(1, 32'h3058, 32'hD000_0003, 64'h7, 1, 0, 1);
        chk("rr_count", 64'(bus.count), 64'd0);
        chk("rr_pc", 64'(bus.PC_out), 64'h3000);
        chk("rr_ready", 64'(bus.in_ready), 64'd1);
        step(1, 32'h3060, 32'hE000_0001, 64'h9, 1, 0, 0);
        chk("rr_resume", 64'(bus.PC_out), 64'h3060);

        // Randomized soak against the model
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) < 7,
                 $urandom, $urandom, {$urandom, $urandom},
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 149) == 0);
        end
        idle(1);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised successor to the CPU's fixed E→M pipeline latch: a stage register for any pipeline boundary that carries IMcode, PC and NCH data words under a valid/ready handshake. It has a 2-entry skid buffer, so `in_ready` has no combinational path from `out_ready`. It also supports synchronous flush and bubble (NOP) insertion. It replaces the hard-wired stage registers between E, M and W when stall/flush control is added to the datapath.

## Interface
- `DATA_W`, default 32: width of each data channel.
- `NCH`, default 2: number of data channels (AO, RT for an E→M boundary).
- `PC_RESET`, default 32'h0000_3000: PC value loaded on reset.
- `NOP_CODE`, default 32'h0000_0000: IMcode value for a bubble.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Flush`  in  1  synchronous; discard all held entries.
- `in_valid`  in  1  upstream offers an entry.
- `in_ready`  out  1  block can accept an entry; a function of registered state only.
- `IMcode_in`  in  32  instruction word.
- `PC_in`  in  32  instruction PC.
- `data_in`  in  DATA_W*NCH  packed channels; channel k is at bits [k*DATA_W +: DATA_W].
- `out_valid`  out  1  main entry is valid.
- `out_ready`  in  1  downstream accepts the main entry.
- `IMcode_out`, `PC_out`, `data_out`  out  32/32/DATA_W*NCH  main entry payload.
- `count`  out  2  occupancy: 0, 1 or 2.

## Operation
- Storage: main register (drives the outputs) and skid register. Each has a valid bit and a payload (IMcode, PC, data).
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- States, encoded by count:
  - EMPTY: main and skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: main and skid valid.
- `in_ready` = (state != FULL).
- `out_valid` = main valid.

Transitions when neither Reset nor Flush is asserted:
- EMPTY:
  - in_fire → main ← input, go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - in_fire & out_fire → main ← input, stay in ONE.
  - in_fire & !out_fire → skid ← input, go to FULL.
  - !in_fire & out_fire → main ← bubble, go to EMPTY.
  - Neither → hold.
- FULL:
  - out_fire → main ← skid, skid ← bubble, go to ONE.
  - Otherwise hold. No in_fire is possible in FULL.

Bubble and reset values:
- Bubble payload is IMcode=NOP_CODE, data=0, PC unchanged. Downstream decode therefore sees a NOP whenever `out_valid`=0.
- Reset (highest priority) sets main and skid to IMcode=NOP_CODE, PC=PC_RESET, data=0, both invalid, state EMPTY.
- Outputs after the Reset edge: `out_valid`=0, `in_ready`=1, `count`=0, `IMcode_out`=NOP_CODE, `PC_out`=PC_RESET, `data_out`=0.
- Inputs presented in the Reset cycle are discarded.

Flush:
- Flush (below Reset, above everything else) sets main and skid to the bubble payload, both invalid, state EMPTY. PC is not reset.
- An in_fire in the Flush cycle is discarded. Upstream sees `in_ready`=1 but the entry is dropped by design; the hazard unit must flush upstream in the same cycle.
- An out_fire in the Flush cycle still counts as consumed downstream.
- Reset or Flush mid-FULL drops both entries. No partial state survives.

Ordering and width rules:
- Entries leave in arrival order.
- No entry is ever duplicated or dropped, except under Reset or Flush.
- Payload bits pass through unmodified; no arithmetic on the data path.

## Timing
- Latency: EMPTY + in_fire at edge N → `out_valid`=1 with that payload after edge N.
- Throughput: one entry per cycle while `out_ready`=1.
- Backpressure: `in_ready` falls one edge after the entry that fills the skid is accepted. At most one extra entry is absorbed after `out_ready` drops.
- Recovery: `in_ready` returns to 1 the edge after out_fire in FULL.
- No combinational path from `out_ready` or `in_valid` to `in_ready`.
- Outputs are registered; the only combinational output logic is count decode.

## Test plan
- Reset: assert Reset for 2 cycles with `in_valid`=1 → `out_valid`=0, `in_ready`=1, `count`=0, `PC_out`=32'h3000, `IMcode_out`=0, `data_out`=0.
- Streaming: `out_ready`=1, push PC 0x3000, 0x3004, 0x3008 on consecutive cycles → each appears one cycle later, `count` stays 1, `in_ready` stays 1.
- Backpressure: `out_ready`=0, push A then B → `count`=2, `in_ready`=0, outputs hold A. Raise `out_ready` → A, then B, each for one cycle; `in_ready`=1 the cycle after A leaves.
- Drain to bubble: ONE with IMcode 0x8C010004, out_fire with no input → `out_valid`=0, `IMcode_out`=NOP_CODE, `data_out`=0, PC unchanged.
- Flush in FULL with simultaneous `in_valid`=1 (PC 0x3010) → `count`=0, `out_valid`=0, and PC 0x3010 never appears at the output.
- Reset mid-stream in FULL → all values as in the reset scenario, then normal streaming resumes the next cycle.
